// File: rtl/ext_ram_pkg.sv
// Shared types and helpers for the external SRAM sequencer.
package ext_ram_pkg;

  // Access phases of one SRAM cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  // Requester identities, also the encoding of the owner output
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  // Wait-state count as used by the strobe counter: 0 acts as 1, 15 is the ceiling
  function automatic logic [3:0] clamp_wait(input int w);
    if (w < 1)
      return 4'd1;
    else if (w > 15)
      return 4'd15;
    else
      return 4'(w);
  endfunction

endpackage

// File: rtl/ram_rr_arbiter.sv
// Two-way round-robin arbiter between the CPU and DMA requesters.
// The grant is combinational; last_grant only advances when the
// sequencer actually accepts the grant (take).
module ram_rr_arbiter
  import ext_ram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_dma,
  input  logic take,
  output logic gnt,
  output logic gnt_vld
);

  logic last_grant;

  // Remember who was served last; DMA after reset so the CPU wins the first tie
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= OWNER_DMA;
    else if (take && gnt_vld)
      last_grant <= gnt;
  end

  // Single request wins outright; a tie goes to whoever was not served last
  always_comb begin
    gnt_vld = req_cpu | req_dma;
    if (req_cpu && req_dma)
      gnt = ~last_grant;
    else if (req_dma)
      gnt = OWNER_DMA;
    else
      gnt = OWNER_CPU;
  end

endmodule

// File: rtl/ext_ram_sequencer.sv
// External 512 KB SRAM access sequencer. Arbitrates CPU and DMA, then runs
// SETUP -> STROBE (W cycles) -> HOLD -> IDLE with every pin registered.
// Output registers are loaded from the next-state decode so that each pin
// changes on the same edge as the state it belongs to.
module ext_ram_sequencer
  import ext_ram_pkg::*;
#(
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 2,
  parameter int AW      = 19
) (
  input  logic          clockIn,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic          dma_ack,
  output logic [7:0]    rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_n_cs,
  output logic          ram_n_oe,
  output logic          ram_n_wr,
  output logic [7:0]    ram_dout,
  output logic          ram_dout_oe,
  input  logic [7:0]    ram_din,
  output logic          busy,
  output logic          owner
);

  localparam logic [3:0] W_RD = clamp_wait(WAIT_RD);
  localparam logic [3:0] W_WR = clamp_wait(WAIT_WR);

  seq_state_t    state, state_nx;
  logic [3:0]    cnt;
  logic          wr_q;
  logic          gnt, gnt_vld, grant;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_wdata;
  logic          nx_wr, nx_owner;
  logic          cs_nx, oe_nx, wr_nx, doe_nx, cack_nx, dack_nx, busy_nx;

  ram_rr_arbiter u_arb (
    .clk     (clockIn),
    .reset   (reset),
    .req_cpu (cpu_req),
    .req_dma (dma_req),
    .take    (state == IDLE),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  assign grant = (state == IDLE) && gnt_vld;

  // Route the granted requester's fields toward the working registers
  always_comb begin
    if (gnt == OWNER_DMA) begin
      sel_wr    = dma_wr;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end else begin
      sel_wr    = cpu_wr;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end
  end

  // State register
  always_ff @(posedge clockIn) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state decode; STROBE leaves once the wait counter is down to 1
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_vld) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (cnt <= 4'd1) state_nx = HOLD;
      HOLD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working copy of the granted request, wait counter and read capture
  always_ff @(posedge clockIn) begin
    if (reset) begin
      wr_q     <= 1'b0;
      owner    <= OWNER_CPU;
      ram_addr <= '0;
      ram_dout <= '0;
      cnt      <= '0;
      rdata    <= '0;
    end else begin
      if (grant) begin
        wr_q     <= sel_wr;
        owner    <= gnt;
        ram_addr <= sel_addr;
        if (sel_wr)
          ram_dout <= sel_wdata;
      end
      if (state == SETUP)
        cnt <= wr_q ? W_WR : W_RD;
      else if (state == STROBE)
        cnt <= cnt - 4'd1;
      if (state == STROBE && cnt <= 4'd1 && !wr_q)
        rdata <= ram_din;
    end
  end

  // Pin values for the state being entered; the direction comes from the
  // request being granted this edge, otherwise from the latched copy
  always_comb begin
    nx_wr    = grant ? sel_wr : wr_q;
    nx_owner = grant ? gnt    : owner;
    busy_nx  = (state_nx != IDLE);
    cs_nx    = ~busy_nx;
    oe_nx    = ~((state_nx == STROBE) && !nx_wr);
    wr_nx    = ~((state_nx == STROBE) &&  nx_wr);
    doe_nx   = busy_nx && nx_wr;
    cack_nx  = (state_nx == HOLD) && (nx_owner == OWNER_CPU);
    dack_nx  = (state_nx == HOLD) && (nx_owner == OWNER_DMA);
  end

  // Registered SRAM strobes, pad enable, acks and busy
  always_ff @(posedge clockIn) begin
    if (reset) begin
      ram_n_cs    <= 1'b1;
      ram_n_oe    <= 1'b1;
      ram_n_wr    <= 1'b1;
      ram_dout_oe <= 1'b0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ram_n_cs    <= cs_nx;
      ram_n_oe    <= oe_nx;
      ram_n_wr    <= wr_nx;
      ram_dout_oe <= doe_nx;
      cpu_ack     <= cack_nx;
      dma_ack     <= dack_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_ext_ram_sequencer.sv
// Directed bench for ext_ram_sequencer. Instance u_dut uses WAIT_RD=2,
// WAIT_WR=3; instance u_dut0 shares the inputs and uses WAIT_RD=0.
module tb_ext_ram_sequencer;

  logic        clockIn = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, dma_req, dma_wr;
  logic [18:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, ram_din;

  logic        cpu_ack, dma_ack, ram_n_cs, ram_n_oe, ram_n_wr, ram_dout_oe, busy, owner;
  logic [7:0]  rdata, ram_dout;
  logic [18:0] ram_addr;

  logic        b_cpu_ack, b_dma_ack, b_ram_n_cs, b_ram_n_oe, b_ram_n_wr, b_ram_dout_oe, b_busy, b_owner;
  logic [7:0]  b_rdata, b_ram_dout;
  logic [18:0] b_ram_addr;

  always #5 clockIn = ~clockIn;

  ext_ram_sequencer #(.WAIT_RD(2), .WAIT_WR(3), .AW(19)) u_dut (
    .clockIn(clockIn), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .rdata(rdata), .ram_addr(ram_addr), .ram_n_cs(ram_n_cs), .ram_n_oe(ram_n_oe), .ram_n_wr(ram_n_wr),
    .ram_dout(ram_dout), .ram_dout_oe(ram_dout_oe), .ram_din(ram_din), .busy(busy), .owner(owner)
  );

  ext_ram_sequencer #(.WAIT_RD(0), .WAIT_WR(2), .AW(19)) u_dut0 (
    .clockIn(clockIn), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(b_cpu_ack),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(b_dma_ack),
    .rdata(b_rdata), .ram_addr(b_ram_addr), .ram_n_cs(b_ram_n_cs), .ram_n_oe(b_ram_n_oe), .ram_n_wr(b_ram_n_wr),
    .ram_dout(b_ram_dout), .ram_dout_oe(b_ram_dout_oe), .ram_din(ram_din), .busy(b_busy), .owner(b_owner)
  );

  int checks = 0;
  int errors = 0;
  int n_viol = 0;
  int c_oe, c_wr, c_doe, c_cack, c_dack, f_cack, f_dack, l_cack, f_oe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin-level invariants of u_dut, sampled once per cycle
  task automatic snoop();
    if (cpu_ack && dma_ack) n_viol++;
    if (!ram_n_oe && !ram_n_wr) n_viol++;
    if (ram_n_cs && (!ram_n_oe || !ram_n_wr)) n_viol++;
    if (ram_dout_oe && !ram_n_oe) n_viol++;
  endtask

  task automatic tick();
    @(posedge clockIn); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Run n cycles from the grant edge; cycle 1 is the first after it.
  // Each requester drops req on its drop_after-th ack.
  task automatic watch(input int n, input int drop_after);
    c_oe = 0; c_wr = 0; c_doe = 0; c_cack = 0; c_dack = 0;
    f_cack = -1; f_dack = -1; l_cack = -1; f_oe = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      snoop();
      if (!ram_n_oe) begin c_oe++; if (f_oe < 0) f_oe = i; end
      if (!ram_n_wr) c_wr++;
      if (ram_dout_oe) c_doe++;
      if (cpu_ack) begin
        c_cack++; l_cack = i;
        if (f_cack < 0) f_cack = i;
        if (c_cack == drop_after) cpu_req = 1'b0;
      end
      if (dma_ack) begin
        c_dack++;
        if (f_dack < 0) f_dack = i;
        if (c_dack == drop_after) dma_req = 1'b0;
      end
    end
  endtask

  initial begin
    int   nc, nd, na, cs_gap, boe, bf;
    int   tack [6];
    bit   seq  [6];
    bit   started;

    cpu_wr = 0; dma_wr = 0; cpu_addr = '0; dma_addr = '0;
    cpu_wdata = '0; dma_wdata = '0; ram_din = '0;
    do_reset();

    // Reset state
    chk("rst_n_cs", ram_n_cs, 1);
    chk("rst_n_oe", ram_n_oe, 1);
    chk("rst_n_wr", ram_n_wr, 1);
    chk("rst_dout_oe", ram_dout_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_acks", {cpu_ack, dma_ack}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rdata", rdata, 0);

    // CPU read, WAIT_RD=2
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h4_1234; ram_din = 8'hA5;
    watch(6, 1);
    chk("rd_first_oe", f_oe, 2);
    chk("rd_oe_cycles", c_oe, 2);
    chk("rd_ack_cycle", f_cack, 4);
    chk("rd_ack_count", c_cack, 1);
    chk("rd_rdata", rdata, 8'hA5);
    chk("rd_a18_16", ram_addr[18:16], 3'b100);
    chk("rd_dout_oe", c_doe, 0);
    chk("rd_idle_cs", ram_n_cs, 1);
    chk("rd_idle_busy", busy, 0);

    // DMA write, WAIT_WR=3
    dma_req = 1; dma_wr = 1; dma_addr = 19'h7_FFFF; dma_wdata = 8'h3C;
    watch(8, 1);
    chk("wr_doe_cycles", c_doe, 5);
    chk("wr_n_wr_cycles", c_wr, 3);
    chk("wr_oe_cycles", c_oe, 0);
    chk("wr_ack_count", c_dack, 1);
    chk("wr_ack_cycle", f_dack, 5);
    chk("wr_no_cpu_ack", c_cack, 0);
    chk("wr_addr", ram_addr, 19'h7_FFFF);
    chk("wr_dout", ram_dout, 8'h3C);
    chk("wr_owner", owner, 1);

    // Reset during the 2nd STROBE cycle of a write
    do_reset();
    dma_req = 1; dma_wr = 1; dma_addr = 19'h0_0ABC; dma_wdata = 8'hC3;
    tick(); chk("rm_setup_n_wr", ram_n_wr, 1);
    tick(); chk("rm_strobe1_n_wr", ram_n_wr, 0);
    tick(); chk("rm_strobe2_n_wr", ram_n_wr, 0);
    reset = 1; dma_req = 0;
    tick();
    chk("rm_strobes", {ram_n_cs, ram_n_oe, ram_n_wr}, 3'b111);
    chk("rm_dout_oe", ram_dout_oe, 0);
    chk("rm_ack", {cpu_ack, dma_ack}, 0);
    chk("rm_busy", busy, 0);
    reset = 0;
    watch(6, 1);
    chk("rm_no_late_ack", c_dack, 0);
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h0_0055; ram_din = 8'h5A;
    watch(6, 1);
    chk("rm_rd_ack_cycle", f_cack, 4);
    chk("rm_rd_rdata", rdata, 8'h5A);

    // WAIT_RD=0 instance: behaves as one wait state
    do_reset();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h0_0321; ram_din = 8'h77;
    boe = 0; bf = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (!b_ram_n_oe) boe++;
      if (b_cpu_ack && bf < 0) begin bf = i; cpu_req = 0; end
    end
    chk("w0_oe_cycles", boe, 1);
    chk("w0_ack_cycle", bf, 3);
    chk("w0_rdata", b_rdata, 8'h77);

    // Requester holds req across ack: second access after the IDLE cycle
    do_reset();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h1_0000; ram_din = 8'h42;
    watch(12, 2);
    chk("hold_ack_count", c_cack, 2);
    chk("hold_first_ack", f_cack, 4);
    chk("hold_second_ack", l_cack, 9);

    // Simultaneous requests, three accesses each: strict alternation
    do_reset();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h0_0100;
    dma_req = 1; dma_wr = 0; dma_addr = 19'h0_0200; ram_din = 8'h11;
    nc = 0; nd = 0; na = 0; cs_gap = 0; started = 0;
    for (int i = 1; i <= 60 && na < 6; i++) begin
      tick();
      snoop();
      if (!ram_n_cs) started = 1;
      else if (started) cs_gap++;
      if (cpu_ack && na < 6) begin
        seq[na] = 0; tack[na] = i; na++; nc++;
        if (nc == 3) cpu_req = 0;
      end
      if (dma_ack && na < 6) begin
        seq[na] = 1; tack[na] = i; na++; nd++;
        if (nd == 3) dma_req = 0;
      end
    end
    chk("rr_total_acks", na, 6);
    chk("rr_first_ack", tack[0], 4);
    for (int k = 0; k < 6; k++)
      chk($sformatf("rr_grant%0d", k), seq[k], k % 2);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_spacing%0d", k), tack[k+1] - tack[k], 5);
    chk("rr_idle_gaps", cs_gap, 5);

    chk("invariants", n_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
